// File: rtl/sbp_lookup_stage_v2.sv
// One stage of a pipelined prefix-tree lookup with node memory,
// write-first update path and a saturating match counter.
module sbp_lookup_stage_v2 #(
  parameter int STAGE_ID      = 1,
  parameter int STAGE_ID_BITS = 6,
  parameter int LOCATION_BITS = 11,
  parameter int IP_BITS       = 32,
  parameter int PLEN_BITS     = $clog2(IP_BITS+1),
  parameter int CNT_BITS      = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   valid_i,
  input  logic                                   update_i,
  input  logic                                   done_i,
  input  logic [IP_BITS-1:0]                     ip_addr_i,
  input  logic [PLEN_BITS-1:0]                   bit_pos_i,
  input  logic [STAGE_ID_BITS-1:0]               stage_id_i,
  input  logic [LOCATION_BITS-1:0]               location_i,
  input  logic                                   result_valid_i,
  input  logic [STAGE_ID_BITS+LOCATION_BITS-1:0] result_i,
  input  logic [PLEN_BITS-1:0]                   wr_len_i,
  input  logic [STAGE_ID_BITS-1:0]               wr_child_stage_i,
  input  logic [LOCATION_BITS-1:0]               wr_child_loc_i,
  input  logic                                   wr_has_left_i,
  input  logic                                   wr_has_right_i,
  output logic                                   valid_o,
  output logic                                   update_o,
  output logic                                   done_o,
  output logic [IP_BITS-1:0]                     ip_addr_o,
  output logic [PLEN_BITS-1:0]                   bit_pos_o,
  output logic [STAGE_ID_BITS-1:0]               stage_id_o,
  output logic [LOCATION_BITS-1:0]               location_o,
  output logic                                   result_valid_o,
  output logic [STAGE_ID_BITS+LOCATION_BITS-1:0] result_o,
  output logic [PLEN_BITS-1:0]                   wr_len_o,
  output logic [STAGE_ID_BITS-1:0]               wr_child_stage_o,
  output logic [LOCATION_BITS-1:0]               wr_child_loc_o,
  output logic                                   wr_has_left_o,
  output logic                                   wr_has_right_o,
  output logic [CNT_BITS-1:0]                    match_cnt_o
);

  localparam int RES_BITS = STAGE_ID_BITS + LOCATION_BITS;
  localparam int DEPTH    = 1 << LOCATION_BITS;

  typedef struct packed {
    logic [IP_BITS-1:0]       prefix;
    logic [PLEN_BITS-1:0]     len;
    logic [STAGE_ID_BITS-1:0] child_stage;
    logic [LOCATION_BITS-1:0] child_loc;
    logic                     has_left;
    logic                     has_right;
  } node_t;

  typedef struct packed {
    logic                     valid;
    logic                     update;
    logic                     done;
    logic [IP_BITS-1:0]       ip;
    logic [PLEN_BITS-1:0]     bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic                     result_valid;
    logic [RES_BITS-1:0]      result;
    logic [PLEN_BITS-1:0]     wr_len;
    logic [STAGE_ID_BITS-1:0] wr_child_stage;
    logic [LOCATION_BITS-1:0] wr_child_loc;
    logic                     wr_has_left;
    logic                     wr_has_right;
  } slot_t;

  node_t mem [DEPTH];
  node_t wr_word, rd_q, byp_q, node;
  slot_t in_s, s1_q, s2_d, out_q;

  logic id_hit, wr_en, sel, sel_q, byp_hit_q;
  logic match, in_range, right, has_child;
  logic [IP_BITS-1:0]  mask, bit_sel;
  logic [CNT_BITS-1:0] cnt_q;

  assign id_hit = stage_id_i == STAGE_ID_BITS'(STAGE_ID);
  assign wr_en  = valid_i & update_i & id_hit;
  assign sel    = valid_i & ~update_i & ~done_i & id_hit;

  assign wr_word = '{
    prefix:      ip_addr_i,
    len:         wr_len_i,
    child_stage: wr_child_stage_i,
    child_loc:   wr_child_loc_i,
    has_left:    wr_has_left_i,
    has_right:   wr_has_right_i
  };

  assign in_s = '{
    valid:          valid_i,
    update:         update_i,
    done:           done_i,
    ip:             ip_addr_i,
    bit_pos:        bit_pos_i,
    stage_id:       stage_id_i,
    location:       location_i,
    result_valid:   result_valid_i,
    result:         result_i,
    wr_len:         wr_len_i,
    wr_child_stage: wr_child_stage_i,
    wr_child_loc:   wr_child_loc_i,
    wr_has_left:    wr_has_left_i,
    wr_has_right:   wr_has_right_i
  };

  always_ff @(posedge clk) begin
    if (wr_en) mem[location_i] <= wr_word;
    rd_q  <= mem[location_i];
    byp_q <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      sel_q     <= 1'b0;
      byp_hit_q <= 1'b0;
      out_q     <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= in_s;
      sel_q     <= sel;
      // a read in the same cycle as a write to that node returns the new word
      byp_hit_q <= wr_en;
      out_q     <= s2_d;
      if (sel_q && match && !(&cnt_q))
        cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  always_comb begin
    node     = byp_hit_q ? byp_q : rd_q;
    mask     = ~({IP_BITS{1'b1}} >> node.len);
    match    = ((s1_q.ip ^ node.prefix) & mask) == '0;
    in_range = s1_q.bit_pos < PLEN_BITS'(IP_BITS);
    bit_sel  = {1'b1, {(IP_BITS-1){1'b0}}} >> s1_q.bit_pos;
    right    = |(s1_q.ip & bit_sel);
    has_child = in_range & (right ? node.has_right : node.has_left);
    s2_d = s1_q;
    if (sel_q) begin
      s2_d.bit_pos = in_range ? s1_q.bit_pos + PLEN_BITS'(1)
                              : PLEN_BITS'(IP_BITS);
      if (has_child) begin
        s2_d.stage_id = node.child_stage;
        s2_d.location = node.child_loc + LOCATION_BITS'(right);
      end else begin
        s2_d.done = 1'b1;
      end
      if (match) begin
        s2_d.result_valid = 1'b1;
        s2_d.result = {STAGE_ID_BITS'(STAGE_ID), s1_q.location};
      end
    end
  end

  assign valid_o          = out_q.valid;
  assign update_o         = out_q.update;
  assign done_o           = out_q.done;
  assign ip_addr_o        = out_q.ip;
  assign bit_pos_o        = out_q.bit_pos;
  assign stage_id_o       = out_q.stage_id;
  assign location_o       = out_q.location;
  assign result_valid_o   = out_q.result_valid;
  assign result_o         = out_q.result;
  assign wr_len_o         = out_q.wr_len;
  assign wr_child_stage_o = out_q.wr_child_stage;
  assign wr_child_loc_o   = out_q.wr_child_loc;
  assign wr_has_left_o    = out_q.wr_has_left;
  assign wr_has_right_o   = out_q.wr_has_right;
  assign match_cnt_o      = cnt_q;

endmodule

// File: tb/tb_sbp_lookup_stage_v2.sv
// Scoreboard bench for sbp_lookup_stage_v2: an IPv4 stage with a wide
// counter and an IPv6 stage with a 4-bit counter.
module tb_sbp_lookup_stage_v2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // IPv4 instance
  logic        a_valid_i, a_update_i, a_done_i, a_rv_i;
  logic [31:0] a_ip_i;
  logic [5:0]  a_bp_i, a_sid_i, a_wlen_i, a_wcs_i;
  logic [10:0] a_loc_i, a_wcl_i;
  logic [16:0] a_res_i;
  logic        a_whl_i, a_whr_i;
  logic        a_valid_o, a_update_o, a_done_o, a_rv_o;
  logic [31:0] a_ip_o;
  logic [5:0]  a_bp_o, a_sid_o, a_wlen_o, a_wcs_o;
  logic [10:0] a_loc_o, a_wcl_o;
  logic [16:0] a_res_o;
  logic        a_whl_o, a_whr_o;
  logic [31:0] a_cnt_o;

  sbp_lookup_stage_v2 u_a (
    .clk(clk), .rst(rst),
    .valid_i(a_valid_i), .update_i(a_update_i), .done_i(a_done_i),
    .ip_addr_i(a_ip_i), .bit_pos_i(a_bp_i), .stage_id_i(a_sid_i),
    .location_i(a_loc_i), .result_valid_i(a_rv_i), .result_i(a_res_i),
    .wr_len_i(a_wlen_i), .wr_child_stage_i(a_wcs_i),
    .wr_child_loc_i(a_wcl_i), .wr_has_left_i(a_whl_i),
    .wr_has_right_i(a_whr_i),
    .valid_o(a_valid_o), .update_o(a_update_o), .done_o(a_done_o),
    .ip_addr_o(a_ip_o), .bit_pos_o(a_bp_o), .stage_id_o(a_sid_o),
    .location_o(a_loc_o), .result_valid_o(a_rv_o), .result_o(a_res_o),
    .wr_len_o(a_wlen_o), .wr_child_stage_o(a_wcs_o),
    .wr_child_loc_o(a_wcl_o), .wr_has_left_o(a_whl_o),
    .wr_has_right_o(a_whr_o), .match_cnt_o(a_cnt_o)
  );

  // IPv6 instance
  logic         b_valid_i, b_update_i, b_done_i, b_rv_i;
  logic [127:0] b_ip_i;
  logic [7:0]   b_bp_i, b_wlen_i;
  logic [5:0]   b_sid_i, b_wcs_i;
  logic [10:0]  b_loc_i, b_wcl_i;
  logic [16:0]  b_res_i;
  logic         b_whl_i, b_whr_i;
  logic         b_valid_o, b_update_o, b_done_o, b_rv_o;
  logic [127:0] b_ip_o;
  logic [7:0]   b_bp_o, b_wlen_o;
  logic [5:0]   b_sid_o, b_wcs_o;
  logic [10:0]  b_loc_o, b_wcl_o;
  logic [16:0]  b_res_o;
  logic         b_whl_o, b_whr_o;
  logic [3:0]   b_cnt_o;

  sbp_lookup_stage_v2 #(.IP_BITS(128), .CNT_BITS(4)) u_b (
    .clk(clk), .rst(rst),
    .valid_i(b_valid_i), .update_i(b_update_i), .done_i(b_done_i),
    .ip_addr_i(b_ip_i), .bit_pos_i(b_bp_i), .stage_id_i(b_sid_i),
    .location_i(b_loc_i), .result_valid_i(b_rv_i), .result_i(b_res_i),
    .wr_len_i(b_wlen_i), .wr_child_stage_i(b_wcs_i),
    .wr_child_loc_i(b_wcl_i), .wr_has_left_i(b_whl_i),
    .wr_has_right_i(b_whr_i),
    .valid_o(b_valid_o), .update_o(b_update_o), .done_o(b_done_o),
    .ip_addr_o(b_ip_o), .bit_pos_o(b_bp_o), .stage_id_o(b_sid_o),
    .location_o(b_loc_o), .result_valid_o(b_rv_o), .result_o(b_res_o),
    .wr_len_o(b_wlen_o), .wr_child_stage_o(b_wcs_o),
    .wr_child_loc_o(b_wcl_o), .wr_has_left_o(b_whl_o),
    .wr_has_right_o(b_whr_o), .match_cnt_o(b_cnt_o)
  );

  typedef struct {
    logic        upd;
    logic        dn;
    logic [31:0] ip;
    logic [5:0]  bp;
    logic [5:0]  sid;
    logic [10:0] loc;
    logic        rv;
    logic [16:0] res;
    logic [5:0]  wlen;
    logic [10:0] wcl;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cnt_exp = 0;

  // Scoreboard: every valid output slot is matched against the queue head
  always @(negedge clk) begin
    if (a_valid_o === 1'b1) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_slot got sid=%0d loc=%0d want none",
                 a_sid_o, a_loc_o);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if ({a_update_o, a_done_o, a_ip_o, a_bp_o, a_sid_o, a_loc_o,
             a_rv_o, a_res_o, a_wlen_o, a_wcl_o} !==
            {e.upd, e.dn, e.ip, e.bp, e.sid, e.loc,
             e.rv, e.res, e.wlen, e.wcl}) begin
          miscompares++;
          $display({"FAIL slot ip=%h got upd=%b dn=%b bp=%0d sid=%0d ",
                    "loc=%0d rv=%b res=%h wl=%0d wcl=%0d want upd=%b ",
                    "dn=%b bp=%0d sid=%0d loc=%0d rv=%b res=%h wl=%0d ",
                    "wcl=%0d"},
                   e.ip, a_update_o, a_done_o, a_bp_o, a_sid_o, a_loc_o,
                   a_rv_o, a_res_o, a_wlen_o, a_wcl_o, e.upd, e.dn, e.bp,
                   e.sid, e.loc, e.rv, e.res, e.wlen, e.wcl);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic a_idle();
    a_valid_i = 0; a_update_i = 0; a_done_i = 0;
  endtask

  task automatic set_wr(input logic [5:0] len, input logic [5:0] cs,
                        input logic [10:0] cl, input logic hl,
                        input logic hr);
    a_wlen_i = len; a_wcs_i = cs; a_wcl_i = cl;
    a_whl_i = hl; a_whr_i = hr;
  endtask

  task automatic push_exp(input logic upd, input logic dn,
                          input logic [31:0] ip, input logic [5:0] bp,
                          input logic [5:0] sid, input logic [10:0] loc,
                          input logic rv, input logic [16:0] res);
    sbq.push_back('{upd, dn, ip, bp, sid, loc, rv, res,
                    a_wlen_i, a_wcl_i});
  endtask

  task automatic slot(input logic v, input logic u, input logic d,
                      input logic [31:0] ip, input logic [5:0] bp,
                      input logic [5:0] sid, input logic [10:0] loc,
                      input logic rv, input logic [16:0] res);
    a_valid_i = v; a_update_i = u; a_done_i = d;
    a_ip_i = ip; a_bp_i = bp; a_sid_i = sid; a_loc_i = loc;
    a_rv_i = rv; a_res_i = res;
    @(negedge clk);
    a_idle();
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending got %0d slots want 0", tag, sbq.size());
      sbq.delete();
    end
    vectors++;
    if (a_cnt_o !== cnt_exp) begin
      miscompares++;
      $display("FAIL %s_count got %0d want %0d", tag, a_cnt_o, cnt_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    a_idle();
    repeat (3) @(negedge clk);
    vectors++;
    if ({a_valid_o, a_update_o, a_done_o, a_rv_o, a_cnt_o, a_sid_o,
         a_loc_o, a_ip_o, a_res_o, b_valid_o, b_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b u=%b d=%b rv=%b cnt=%0d want 0",
               a_valid_o, a_update_o, a_done_o, a_rv_o, a_cnt_o);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_wr(16, 2, 8, 1, 1);
    push_exp(1, 0, 32'hC0A80000, 0, 1, 5, 0, 0);
    slot(1, 1, 0, 32'hC0A80000, 0, 1, 5, 0, 0);
    set_wr(0, 0, 0, 0, 0);
    @(negedge clk);
    push_exp(0, 0, 32'hC0A80101, 17, 2, 8, 1, {6'd1, 11'd5});
    slot(1, 0, 0, 32'hC0A80101, 16, 1, 5, 0, 0);
    push_exp(0, 0, 32'hC0A88000, 17, 2, 9, 1, {6'd1, 11'd5});
    slot(1, 0, 0, 32'hC0A88000, 16, 1, 5, 0, 0);
    push_exp(0, 0, 32'h0A000001, 17, 2, 8, 1, {6'd3, 11'd100});
    slot(1, 0, 0, 32'h0A000001, 16, 1, 5, 1, {6'd3, 11'd100});
    cnt_exp = 2;
    drain("basic");
  endtask

  task automatic test_passthrough();
    set_wr(0, 0, 0, 0, 0);
    slot(0, 1, 0, 32'h0, 0, 1, 5, 0, 0);
    push_exp(0, 0, 32'hC0A80101, 16, 2, 5, 0, 0);
    slot(1, 0, 0, 32'hC0A80101, 16, 2, 5, 0, 0);
    push_exp(0, 0, 32'hC0A80101, 17, 2, 8, 1, {6'd1, 11'd5});
    slot(1, 0, 0, 32'hC0A80101, 16, 1, 5, 0, 0);
    cnt_exp = 3;
    drain("passthrough");
  endtask

  task automatic test_write_first();
    set_wr(8, 5, 30, 1, 1);
    push_exp(1, 0, 32'h11000000, 0, 1, 7, 0, 0);
    slot(1, 1, 0, 32'h11000000, 0, 1, 7, 0, 0);
    set_wr(8, 6, 40, 1, 1);
    push_exp(1, 0, 32'h22000000, 0, 1, 7, 0, 0);
    slot(1, 1, 0, 32'h22000000, 0, 1, 7, 0, 0);
    push_exp(0, 0, 32'h22000000, 9, 6, 40, 1, {6'd1, 11'd7});
    slot(1, 0, 0, 32'h22000000, 8, 1, 7, 0, 0);
    cnt_exp = 4;
    drain("write_first");
  endtask

  task automatic test_done();
    set_wr(0, 3, 20, 1, 0);
    push_exp(1, 0, 32'h0, 0, 1, 10, 0, 0);
    slot(1, 1, 0, 32'h0, 0, 1, 10, 0, 0);
    push_exp(0, 1, 32'h80000000, 1, 1, 10, 1, {6'd1, 11'd10});
    slot(1, 0, 0, 32'h80000000, 0, 1, 10, 0, 0);
    push_exp(0, 1, 32'h80000000, 1, 1, 10, 1, {6'd1, 11'd10});
    slot(1, 0, 1, 32'h80000000, 1, 1, 10, 1, {6'd1, 11'd10});
    cnt_exp = 5;
    drain("done");
  endtask

  task automatic test_boundary();
    push_exp(0, 1, 32'hFFFFFFFF, 32, 1, 10, 1, {6'd1, 11'd10});
    slot(1, 0, 0, 32'hFFFFFFFF, 32, 1, 10, 0, 0);
    set_wr(0, 4, 2047, 1, 1);
    push_exp(1, 0, 32'h0, 0, 1, 11, 0, 0);
    slot(1, 1, 0, 32'h0, 0, 1, 11, 0, 0);
    push_exp(0, 0, 32'h1, 32, 4, 0, 1, {6'd1, 11'd11});
    slot(1, 0, 0, 32'h1, 31, 1, 11, 0, 0);
    push_exp(0, 0, 32'h0, 32, 4, 2047, 1, {6'd1, 11'd11});
    slot(1, 0, 0, 32'h0, 31, 1, 11, 0, 0);
    set_wr(32, 0, 0, 0, 0);
    push_exp(1, 0, 32'h12345678, 0, 1, 12, 0, 0);
    slot(1, 1, 0, 32'h12345678, 0, 1, 12, 0, 0);
    push_exp(0, 1, 32'h12345679, 1, 1, 12, 0, 0);
    slot(1, 0, 0, 32'h12345679, 0, 1, 12, 0, 0);
    push_exp(0, 1, 32'h12345678, 1, 1, 12, 1, {6'd1, 11'd12});
    slot(1, 0, 0, 32'h12345678, 0, 1, 12, 0, 0);
    cnt_exp = 9;
    drain("boundary");
  endtask

  task automatic test_reset_midstream();
    push_exp(0, 1, 32'hFFFFFFFF, 32, 1, 10, 1, {6'd1, 11'd10});
    slot(1, 0, 0, 32'hFFFFFFFF, 32, 1, 10, 0, 0);
    slot(1, 0, 0, 32'hC0A80101, 16, 1, 5, 0, 0);
    rst = 1;
    @(negedge clk);
    vectors++;
    if ({a_valid_o, a_sid_o, a_loc_o, a_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_flush got v=%b sid=%0d loc=%0d cnt=%0d want 0",
               a_valid_o, a_sid_o, a_loc_o, a_cnt_o);
    end
    rst = 0;
    @(negedge clk);
    vectors++;
    if (a_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_flush2 got v=%b want 0", a_valid_o);
    end
    cnt_exp = 0;
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ip;
      ip = 32'hC0A80000 + 32'(i) * 32'h4000;
      push_exp(0, 0, ip, 17, 2, 11'(8 + i / 2), 1, {6'd1, 11'd5});
      slot(1, 0, 0, ip, 16, 1, 5, 0, 0);
    end
    cnt_exp = 4;
    drain("back_to_back");
  endtask

  task automatic b_slot(input logic u, input logic [127:0] ip,
                        input logic [7:0] bp);
    b_valid_i = 1; b_update_i = u; b_ip_i = ip; b_bp_i = bp;
    @(negedge clk);
    b_valid_i = 0; b_update_i = 0;
  endtask

  task automatic test_ipv6();
    logic [127:0] pfx;
    pfx = {64'hDEADBEEF01234567, 64'h0};
    b_sid_i = 1; b_loc_i = 3; b_wlen_i = 64;
    b_wcs_i = 0; b_wcl_i = 0; b_whl_i = 0; b_whr_i = 0;
    b_slot(1, pfx, 0);
    b_slot(0, {64'hDEADBEEF01234567, 64'hFFFFFFFFFFFFFFFF}, 0);
    @(negedge clk);
    vectors++;
    if ({b_valid_o, b_done_o, b_rv_o, b_res_o, b_bp_o, b_cnt_o} !==
        {1'b1, 1'b1, 1'b1, 6'd1, 11'd3, 8'd1, 4'd1}) begin
      miscompares++;
      $display("FAIL v6_match got v=%b d=%b rv=%b res=%h bp=%0d cnt=%0d",
               b_valid_o, b_done_o, b_rv_o, b_res_o, b_bp_o, b_cnt_o);
    end
    b_slot(0, {64'hDEADBEEF01234566, 64'h0}, 0);
    @(negedge clk);
    vectors++;
    if ({b_valid_o, b_rv_o, b_cnt_o} !== {1'b1, 1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL v6_nomatch got v=%b rv=%b cnt=%0d want 1 0 1",
               b_valid_o, b_rv_o, b_cnt_o);
    end
    for (int i = 0; i < 14; i++) b_slot(0, pfx, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (b_cnt_o !== 4'd15) begin
      miscompares++;
      $display("FAIL v6_cnt15 got %0d want 15", b_cnt_o);
    end
    for (int i = 0; i < 3; i++) b_slot(0, pfx, 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (b_cnt_o !== 4'd15) begin
      miscompares++;
      $display("FAIL v6_saturate got %0d want 15", b_cnt_o);
    end
  endtask

  initial begin
    rst = 1;
    a_idle();
    set_wr(0, 0, 0, 0, 0);
    a_ip_i = 0; a_bp_i = 0; a_sid_i = 0; a_loc_i = 0;
    a_rv_i = 0; a_res_i = 0;
    b_valid_i = 0; b_update_i = 0; b_done_i = 0; b_rv_i = 0;
    b_ip_i = 0; b_bp_i = 0; b_sid_i = 0; b_loc_i = 0; b_res_i = 0;
    b_wlen_i = 0; b_wcs_i = 0; b_wcl_i = 0; b_whl_i = 0; b_whr_i = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_passthrough();
    test_write_first();
    test_done();
    test_boundary();
    test_reset_midstream();
    test_back_to_back();
    test_ipv6();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
